result_collector: RTL and testbench

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector_pkg.sv | 23 ++
 rtl/result_reduce_step.sv | 30 +++
 rtl/result_collector.sv | 136 +++++++++++++
 tb/tb_result_collector.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_collector_pkg.sv
// rtl/result_collector_pkg.sv - shared state encoding, defaults and sum width for the result collector
package result_collector_pkg;

  // Default result word width and slots per frame
  localparam int DEFAULT_DW    = 8;
  localparam int DEFAULT_NSLOT = 4;

  // Guard bits on the sum so four full-scale words can never overflow
  localparam int SUM_GUARD = 2;

  // Collector phases: fill slots, walk them one per edge, then hold the summary
  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_REDUCE  = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  // Width of the frame sum for a given word width
  function automatic int sum_width(input int dw);
    return dw + SUM_GUARD;
  endfunction

endpackage

// File: rtl/result_reduce_step.sv
// rtl/result_reduce_step.sv - one signed reduce step: accumulate and track max/min
module result_reduce_step
  import result_collector_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int SW = sum_width(DEFAULT_DW)
) (
  input  logic                 first,
  input  logic signed [SW-1:0] acc_sum,
  input  logic signed [DW-1:0] acc_max,
  input  logic signed [DW-1:0] acc_min,
  input  logic signed [DW-1:0] slot_val,
  output logic signed [SW-1:0] next_sum,
  output logic signed [DW-1:0] next_max,
  output logic signed [DW-1:0] next_min
);

  logic signed [SW-1:0] slot_ext;
  logic signed [SW-1:0] base_sum;

  // Sign-extend the slot and fold it in; the first slot seeds max/min and the sum starts at zero
  always_comb begin
    slot_ext = {{(SW-DW){slot_val[DW-1]}}, slot_val};
    base_sum = first ? '0 : acc_sum;
    next_sum = base_sum + slot_ext;
    next_max = (first || (slot_val > acc_max)) ? slot_val : acc_max;
    next_min = (first || (slot_val < acc_min)) ? slot_val : acc_min;
  end

endmodule

// File: rtl/result_collector.sv
// rtl/result_collector.sv - gathers one frame of result words and presents sum/max/min
module result_collector
  import result_collector_pkg::*;
#(
  parameter int  DW    = DEFAULT_DW,
  parameter int  NSLOT = DEFAULT_NSLOT,
  localparam int AW    = $clog2(NSLOT),
  localparam int SW    = sum_width(DW)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 WEB,
  input  logic [AW-1:0]        AddrB,
  input  logic signed [DW-1:0] DataInB,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic signed [SW-1:0] out_sum,
  output logic signed [DW-1:0] out_max,
  output logic signed [DW-1:0] out_min,
  output logic                 busy,
  output logic                 drop
);

  state_t               state;
  logic [NSLOT-1:0]     mask;
  logic [AW-1:0]        idx;
  logic signed [DW-1:0] slots [NSLOT];

  logic signed [SW-1:0] acc_sum;
  logic signed [DW-1:0] acc_max;
  logic signed [DW-1:0] acc_min;

  logic signed [SW-1:0] step_sum;
  logic signed [DW-1:0] step_max;
  logic signed [DW-1:0] step_min;

  logic [NSLOT-1:0]     wr_bit;
  logic [NSLOT-1:0]     mask_next;
  logic                 handshake;
  logic                 slot_we;
  logic                 last_slot;

  assign wr_bit    = {{(NSLOT-1){1'b0}}, 1'b1} << AddrB;
  assign mask_next = mask | wr_bit;
  assign handshake = (state == ST_PRESENT) && out_ready;
  assign slot_we   = WEB && ((state == ST_COLLECT) || handshake);
  assign last_slot = (idx == AW'(NSLOT - 1));

  result_reduce_step #(
    .DW (DW),
    .SW (SW)
  ) u_step (
    .first    (idx == '0),
    .acc_sum  (acc_sum),
    .acc_max  (acc_max),
    .acc_min  (acc_min),
    .slot_val (slots[idx]),
    .next_sum (step_sum),
    .next_max (step_max),
    .next_min (step_min)
  );

  // Slot register file: accepts writes while collecting and on the handshake edge
  always_ff @(posedge clk) begin
    if (!reset && slot_we) begin
      slots[AddrB] <= DataInB;
    end
  end

  // Frame FSM: fill mask, one-slot-per-edge reduction, then hold the summary until taken
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_COLLECT;
      mask      <= '0;
      idx       <= '0;
      acc_sum   <= '0;
      acc_max   <= '0;
      acc_min   <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_max   <= '0;
      out_min   <= '0;
      busy      <= 1'b0;
      drop      <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (WEB) begin
            mask <= mask_next;
            if (&mask_next) begin
              state <= ST_REDUCE;
              idx   <= '0;
              busy  <= 1'b1;
            end
          end
        end

        ST_REDUCE: begin
          acc_sum <= step_sum;
          acc_max <= step_max;
          acc_min <= step_min;
          idx     <= idx + 1'b1;
          if (WEB) begin
            drop <= 1'b1;
          end
          if (last_slot) begin
            state     <= ST_PRESENT;
            out_valid <= 1'b1;
            out_sum   <= step_sum;
            out_max   <= step_max;
            out_min   <= step_min;
          end
        end

        ST_PRESENT: begin
          if (out_ready) begin
            state     <= ST_COLLECT;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            idx       <= '0;
            mask      <= WEB ? wr_bit : '0;
          end else if (WEB) begin
            drop <= 1'b1;
          end
        end

        default: begin
          state <= ST_COLLECT;
          mask  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - directed self-checking bench for result_collector
module tb_result_collector;
  import result_collector_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              WEB;
  logic [1:0]        AddrB;
  logic signed [7:0] DataInB;
  logic              out_ready;
  logic              out_valid;
  logic signed [9:0] out_sum;
  logic signed [7:0] out_max;
  logic signed [7:0] out_min;
  logic              busy;
  logic              drop;

  int n_tests = 0;
  int n_fail  = 0;

  result_collector dut (
    .clk       (clk),
    .reset     (reset),
    .WEB       (WEB),
    .AddrB     (AddrB),
    .DataInB   (DataInB),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_max   (out_max),
    .out_min   (out_min),
    .busy      (busy),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input logic [1:0] a, input int v);
    WEB     = 1'b1;
    AddrB   = a;
    DataInB = 8'(v);
    tick();
    WEB     = 1'b0;
  endtask

  task automatic write_frame(input int v0, input int v1, input int v2, input int v3);
    write_slot(2'd0, v0);
    write_slot(2'd1, v1);
    write_slot(2'd2, v2);
    write_slot(2'd3, v3);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || drop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: valid=%b busy=%b drop=%b expected 0 0 0", out_valid, busy, drop);
    end
    n_tests++;
    if (out_sum !== 10'd0 || out_max !== 8'd0 || out_min !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_data: sum=%0d max=%0d min=%0d expected 0 0 0", out_sum, out_max, out_min);
    end
    n_tests++;
    if (dut.state !== ST_COLLECT || dut.mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d mask=%b expected 0 0000", dut.state, dut.mask);
    end
    reset = 1'b0;
  endtask

  task automatic test_negative_frame();
    int cyc;
    write_frame(-2, -3, -4, -7);
    n_tests++;
    if (dut.state !== ST_REDUCE || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL neg_enter_reduce: state=%0d busy=%b expected 1 1", dut.state, busy);
    end
    wait_valid(cyc);
    n_tests++;
    if (cyc !== 4) begin
      n_fail++;
      $display("FAIL neg_latency: got %0d cycles expected 4", cyc);
    end
    n_tests++;
    if ($signed(out_sum) !== -16 || $signed(out_max) !== -2 || $signed(out_min) !== -7 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL neg_result: sum=%0d max=%0d min=%0d busy=%b expected -16 -2 -7 1",
               out_sum, out_max, out_min, busy);
    end
    do_handshake();
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || dut.state !== ST_COLLECT) begin
      n_fail++;
      $display("FAIL neg_handshake: valid=%b busy=%b state=%0d expected 0 0 0", out_valid, busy, dut.state);
    end
  endtask

  task automatic test_extremes();
    int cyc;
    write_frame(127, 127, 127, 127);
    wait_valid(cyc);
    n_tests++;
    if ($signed(out_sum) !== 508 || $signed(out_max) !== 127 || $signed(out_min) !== 127) begin
      n_fail++;
      $display("FAIL max_pos: sum=%0d max=%0d min=%0d expected 508 127 127", out_sum, out_max, out_min);
    end
    do_handshake();
    write_frame(-128, -128, -128, -128);
    wait_valid(cyc);
    n_tests++;
    if ($signed(out_sum) !== -512 || $signed(out_max) !== -128 || $signed(out_min) !== -128) begin
      n_fail++;
      $display("FAIL max_neg: sum=%0d max=%0d min=%0d expected -512 -128 -128", out_sum, out_max, out_min);
    end
    do_handshake();
  endtask

  task automatic test_overwrite();
    int cyc;
    write_slot(2'd0, 1);
    write_slot(2'd1, 2);
    write_slot(2'd1, 5);
    write_slot(2'd2, 3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (dut.state !== ST_COLLECT || dut.mask !== 4'b0111 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovw_partial: state=%0d mask=%b valid=%b expected 0 0111 0", dut.state, dut.mask, out_valid);
    end
    write_slot(2'd3, 4);
    n_tests++;
    if (dut.slots[1] !== 8'sd5) begin
      n_fail++;
      $display("FAIL ovw_slot1: got %0d expected 5", dut.slots[1]);
    end
    wait_valid(cyc);
    n_tests++;
    if (cyc !== 4 || $signed(out_sum) !== 13 || $signed(out_max) !== 5 || $signed(out_min) !== 1) begin
      n_fail++;
      $display("FAIL ovw_result: cyc=%0d sum=%0d max=%0d min=%0d expected 4 13 5 1", cyc, out_sum, out_max, out_min);
    end
    do_handshake();
  endtask

  task automatic test_backpressure();
    int cyc;
    bit unstable;
    write_frame(1, 2, 3, 4);
    wait_valid(cyc);
    unstable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      WEB     = (i % 2 == 0);
      AddrB   = 2'(i % 4);
      DataInB = 8'sd99;
      tick();
      if (out_valid !== 1'b1 || $signed(out_sum) !== 10 || $signed(out_max) !== 4 || $signed(out_min) !== 1)
        unstable = 1'b1;
    end
    WEB = 1'b0;
    n_tests++;
    if (unstable !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stable: outputs changed, now valid=%b sum=%0d expected 1 10", out_valid, out_sum);
    end
    n_tests++;
    if (drop !== 1'b1 || dut.state !== ST_PRESENT) begin
      n_fail++;
      $display("FAIL bp_drop: drop=%b state=%0d expected 1 2", drop, dut.state);
    end
    n_tests++;
    if (dut.slots[0] !== 8'sd1 || dut.slots[2] !== 8'sd3) begin
      n_fail++;
      $display("FAIL bp_slots: slot0=%0d slot2=%0d expected 1 3", dut.slots[0], dut.slots[2]);
    end
    do_handshake();
    n_tests++;
    if (dut.state !== ST_COLLECT || dut.mask !== 4'b0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: state=%0d mask=%b valid=%b expected 0 0000 0", dut.state, dut.mask, out_valid);
    end
  endtask

  task automatic test_handshake_write();
    int cyc;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    write_frame(1, 2, 3, 4);
    wait_valid(cyc);
    out_ready = 1'b1;
    WEB       = 1'b1;
    AddrB     = 2'd2;
    DataInB   = -8'sd9;
    tick();
    out_ready = 1'b0;
    WEB       = 1'b0;
    n_tests++;
    if (dut.mask !== 4'b0100 || dut.slots[2] !== -8'sd9) begin
      n_fail++;
      $display("FAIL hs_write: mask=%b slot2=%0d expected 0100 -9", dut.mask, dut.slots[2]);
    end
    n_tests++;
    if (drop !== 1'b0 || dut.state !== ST_COLLECT || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_flags: drop=%b state=%0d valid=%b expected 0 0 0", drop, dut.state, out_valid);
    end
    write_slot(2'd0, 1);
    write_slot(2'd1, 1);
    write_slot(2'd3, 1);
    wait_valid(cyc);
    n_tests++;
    if ($signed(out_sum) !== -6 || $signed(out_max) !== 1 || $signed(out_min) !== -9) begin
      n_fail++;
      $display("FAIL hs_frame: sum=%0d max=%0d min=%0d expected -6 1 -9", out_sum, out_max, out_min);
    end
    do_handshake();
  endtask

  task automatic test_reset_mid_reduce();
    int cyc;
    write_frame(10, 20, 30, 40);
    tick();
    reset   = 1'b1;
    WEB     = 1'b1;
    AddrB   = 2'd1;
    DataInB = 8'sd55;
    tick();
    reset = 1'b0;
    WEB   = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || drop !== 1'b0 ||
        out_sum !== 10'd0 || out_max !== 8'd0 || out_min !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_out: valid=%b busy=%b drop=%b sum=%0d max=%0d min=%0d expected all 0",
               out_valid, busy, drop, out_sum, out_max, out_min);
    end
    n_tests++;
    if (dut.state !== ST_COLLECT || dut.mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_state: state=%0d mask=%b expected 0 0000", dut.state, dut.mask);
    end
    write_frame(5, -6, 7, -8);
    wait_valid(cyc);
    n_tests++;
    if (cyc !== 4 || $signed(out_sum) !== -2 || $signed(out_max) !== 7 || $signed(out_min) !== -8) begin
      n_fail++;
      $display("FAIL midreset_frame: cyc=%0d sum=%0d max=%0d min=%0d expected 4 -2 7 -8",
               cyc, out_sum, out_max, out_min);
    end
    do_handshake();
  endtask

  initial begin
    reset     = 1'b1;
    WEB       = 1'b0;
    AddrB     = 2'd0;
    DataInB   = 8'sd0;
    out_ready = 1'b0;
    test_reset();
    test_negative_frame();
    test_extremes();
    test_overwrite();
    test_backpressure();
    test_handshake_write();
    test_reset_mid_reduce();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
